led_blink_scheduler: RTL
========================

LED_BLINK_SCHEDULER -- requirements
Module: led_blink_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 520000: clocks per blink phase (250 ms at 2.08 MHz).
REQ-002 The block SHALL have parameter GAP_TICKS, default 4: phases of LED-off gap after each service.
REQ-003 The block SHALL have port CLOCK  in  1  single clock, internal oscillator domain.
REQ-004 The block SHALL have port RESETn  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port REQ  in  4  per-requester blink request, level.
REQ-006 The block SHALL have port COUNT  in  16  blink count, 4 bits per requester; requester i uses bits [4i+3:4i].
REQ-007 The block SHALL have port GNT  out  4  one-hot grant, held for the whole service.
REQ-008 The block SHALL have port DONE  out  4  one-cycle completion pulse for the served requester.
REQ-009 The block SHALL have port BUSY  out  1  high whenever the FSM is not IDLE.
REQ-010 The block SHALL have port LEDn  out  1  shared LED, active-low (0 = lit).

Function
REQ-011 The block SHALL use a phase counter counting 0..TICK_DIV-1, cleared on every grant, with a phase tick on terminal count.
REQ-012 The block SHALL implement FSM states IDLE, ON, OFF, GAP, FIN.
REQ-013 IDLE: if any REQ bit is high, the block SHALL grant round-robin starting at the index after the last granted requester, latch that requester's COUNT, and assert GNT from the next cycle.
REQ-014 Latched COUNT=0: the block SHALL go to FIN with no LED activity; GNT and DONE SHALL both be high for exactly one cycle.
REQ-015 Latched COUNT>0: the block SHALL go to ON; LEDn=0 for TICK_DIV cycles, then OFF with LEDn=1 for TICK_DIV cycles, then decrement the remaining count.
REQ-016 OFF end: if remaining count is nonzero the block SHALL return to ON; otherwise it SHALL enter GAP.
REQ-017 GAP: the block SHALL hold LEDn=1 for GAP_TICKS*TICK_DIV cycles, then enter FIN.
REQ-018 FIN: the block SHALL pulse DONE[i] for one cycle with GNT[i] still high, advance the pointer to i, then return to IDLE.
REQ-019 Service SHALL be non-preemptive: REQ changes and COUNT changes during service SHALL be ignored.
REQ-020 A REQ dropped before grant SHALL be withdrawn without any effect.
REQ-021 A requester still holding REQ after DONE SHALL be eligible again only in round-robin order.
REQ-022 GNT SHALL be zero or one-hot at all times; LEDn SHALL be 1 in every state other than ON.
REQ-023 Full service time for COUNT=N>0 SHALL be (2N+GAP_TICKS)*TICK_DIV+1 cycles of GNT.

Reset
REQ-024 RESETn low SHALL asynchronously force LEDn=1, GNT=0, DONE=0, BUSY=0, state IDLE, phase counter 0, and the pointer to 3 so that requester 0 has first priority.
REQ-025 Reset mid-service SHALL abort the service without a DONE pulse.
REQ-026 Reset release SHALL be synchronous to CLOCK.

Configuration
REQ-027 With LED_SCHED_FASTSIM_EN defined, the effective phase length SHALL be 8 cycles regardless of TICK_DIV, and GAP_TICKS SHALL still apply.
REQ-028 With LED_SCHED_FASTSIM_EN undefined, the phase length SHALL be TICK_DIV, and the block SHALL contain no fast-simulation logic.

Verification (TICK_DIV=4, GAP_TICKS=2, macro undefined unless stated)
REQ-029 Reset: hold RESETn=0 with REQ=1111 -> LEDn=1, GNT=0000, DONE=0000, BUSY=0 throughout.
REQ-030 REQ=0001, COUNT0=3: GNT=0001 one cycle later; LEDn low 4, high 4, three times; then 8 high; DONE=0001 pulse; GNT held 33 cycles.
REQ-031 REQ=1111 held, all COUNT=1: grants in order 0,1,2,3,0; each DONE is one cycle; there is no overlap; BUSY drops for exactly one IDLE cycle between services.
REQ-032 REQ=0100, COUNT2=0: GNT=0100 and DONE=0100 in the same single cycle; LEDn stays 1.
REQ-033 RESETn pulsed low during the second ON phase of a COUNT=3 service: LEDn=1 immediately; no DONE; after release REQ=1001 -> requester 0 is granted first.
REQ-034 LED_SCHED_FASTSIM_EN defined, TICK_DIV=520000, COUNT0=1: LEDn low 8 cycles, high 8 cycles, gap 16 cycles, then DONE.

Source files
------------

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: round-robin scheduler that lets four requesters share
// one active-low LED. A granted requester gets N on/off blink pairs, then an
// LED-off gap, then a one-cycle DONE pulse while its grant is still high.
// Optional build macro: LED_SCHED_FASTSIM_EN -- when defined, every blink
// phase lasts 8 clocks regardless of TICK_DIV (gap length still scales by
// GAP_TICKS), so simulations finish quickly.
module led_blink_scheduler #(
  parameter int TICK_DIV  = 520000,
  parameter int GAP_TICKS = 4
) (
  input  logic        CLOCK,
  input  logic        RESETn,
  input  logic [3:0]  REQ,
  input  logic [15:0] COUNT,
  output logic [3:0]  GNT,
  output logic [3:0]  DONE,
  output logic        BUSY,
  output logic        LEDn
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ON   = 3'd1;
  localparam logic [2:0] S_OFF  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

`ifdef LED_SCHED_FASTSIM_EN
  localparam int PHASE_LEN = 8;
`else
  localparam int PHASE_LEN = TICK_DIV;
`endif

  localparam int PH_W  = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       idx_q, idx_d;     // index of the requester being served
  logic [1:0]       ptr_q, ptr_d;     // last requester that completed service
  logic [3:0]       cnt_q, cnt_d;     // blink pairs still to show
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             tick;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [3:0]       win_count;

  assign tick = (phase_q == PH_LAST);

  // Round-robin pick: first asserted REQ starting just after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_count = COUNT[{win_idx, 2'b00} +: 4];

  // Next-state logic; COUNT and REQ are only looked at while IDLE, so a
  // running service cannot be disturbed by either of them.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = 4'b0001 << win_idx;
          idx_d   = win_idx;
          cnt_d   = win_count;
          phase_d = '0;
          gap_d   = '0;
          state_d = (win_count == 4'd0) ? S_FIN : S_ON;
        end
      end
      S_ON: begin
        phase_d = tick ? '0 : phase_q + 1'b1;
        if (tick) state_d = S_OFF;
      end
      S_OFF: begin
        phase_d = tick ? '0 : phase_q + 1'b1;
        if (tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q != 4'd1)       state_d = S_ON;
          else if (GAP_TICKS == 0) state_d = S_FIN;
          else                     state_d = S_GAP;
        end
      end
      S_GAP: begin
        phase_d = tick ? '0 : phase_q + 1'b1;
        if (tick) begin
          if (gap_q == GAP_LAST) state_d = S_FIN;
          else                   gap_d   = gap_q + 1'b1;
        end
      end
      S_FIN: begin
        gnt_d   = 4'b0000;
        ptr_d   = idx_q;
        phase_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 4'b0000;
        phase_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; the pointer resets to 3 so requester 0 wins first.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= 4'd0;
      phase_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign GNT  = gnt_q;
  assign DONE = (state_q == S_FIN) ? gnt_q : 4'b0000;
  assign BUSY = (state_q != S_IDLE);
  assign LEDn = (state_q != S_ON);

endmodule
